gpio_bus_arbiter: RTL and testbench
===================================

# gpio_bus_arbiter

Two-master arbiter and sequencer for the GPIO peripheral's single register port. It accepts read/write requests from master 0 (CPU load/store unit) and master 1 (debug/test sequencer) and grants them round-robin. It issues exactly one single-cycle `rd_en`/`wr_en` strobe per transaction on the GPIO port, and returns an ack (plus read data) to the granted master. It sits between the masters and the GPIO block, which is the only slave.

## Interface
- `DATA_W`, default 32: data width, matching the GPIO `data_in`/`data_out`.
- `ADDR_W`, default 2: GPIO register address width.

- `clk` input 1: single clock.
- `reset_n` input 1: synchronous, active-low reset.
- `m0_req`, `m1_req` input 1: request; held high until the matching ack.
- `m0_we`, `m1_we` input 1: 1 = write, 0 = read; sampled at grant.
- `m0_addr`, `m1_addr` input `ADDR_W`: register address; sampled at grant.
- `m0_wdata`, `m1_wdata` input `DATA_W`: write data; sampled at grant.
- `m0_ack`, `m1_ack` output 1: one-cycle completion pulse.
- `m0_rdata`, `m1_rdata` output `DATA_W`: read data; valid with ack, held until that master's next read completes.
- `gpio_addr` output `ADDR_W`: to GPIO `addr`.
- `gpio_data_in` output `DATA_W`: to GPIO `data_in`.
- `gpio_rd_en`, `gpio_wr_en` output 1: to GPIO strobes.
- `gpio_data_out` input `DATA_W`: from GPIO; registered, valid the cycle after `rd_en`.
- `busy` output 1: high in every state except IDLE.
- `last_grant` output 1: index of the most recently granted master.

## Operation
- FSM states are IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- **IDLE:**
  - If any `mX_req` is high, pick a winner and latch its `we`, `addr` and `wdata`, its index into `last_grant`, then go to ISSUE.
  - If no request is high, stay in IDLE.
- **Arbitration:**
  - If only one request is high, that master wins.
  - If both are high, the master ≠ `last_grant` wins.
  - `last_grant` resets to 1, so m0 wins the first contest after reset.
- **ISSUE:**
  - Drive `gpio_addr` from the latched address.
  - For a write, drive `gpio_data_in` from the latched data and assert `gpio_wr_en` for exactly this cycle, then go to DONE.
  - For a read, assert `gpio_rd_en` for exactly this cycle, then go to WAIT.
- **WAIT:** capture `gpio_data_out` into the granted master's `rdata` register, then go to DONE.
- **DONE:**
  - Pulse the granted master's `mX_ack` for one cycle; go to IDLE.
  - On a write, `rdata` is unchanged.
- **Request release:**
  - A master drops `req` on the clock edge at which it sees ack.
  - If `req` is still high in the following IDLE cycle, it is a new transaction.
  - Request fields are not monitored after grant; changes to them are ignored.
- **Strobes and address:**
  - `gpio_rd_en` and `gpio_wr_en` are never high together, and never high outside ISSUE.
  - `gpio_addr` and `gpio_data_in` hold their last value outside ISSUE; they are not zeroed.
- **Reset** (synchronous, `reset_n` = 0 at a clock edge), in any state including mid-transaction:
  - Next state is IDLE.
  - All acks, strobes and `busy` are 0; `gpio_addr`, `gpio_data_in`, both `rdata` = 0; `last_grant` = 1.
  - No ack is ever issued for the aborted transaction.
- A request arriving while `busy` waits; it is not lost, since `req` is level-held.

## Timing
- Request sampled high at edge E0, in IDLE.
- **Write:** `gpio_wr_en` is high in cycle E0+1 (ISSUE); `mX_ack` is high in cycle E0+2. Latency is 2 cycles; throughput is 1 write per 3 cycles.
- **Read:** `gpio_rd_en` is high in E0+1; `gpio_data_out` is captured at the end of E0+2 (WAIT); `mX_ack` and `rdata` are valid in E0+3. Latency is 3 cycles; throughput is 1 read per 4 cycles.
- Both masters continuously requesting produce strictly alternating grants, m0 first after reset.
- No combinational path exists from any `mX_*` or `gpio_data_out` input to any output.

## Test plan
- **m0 write:** after reset, m0 writes addr=1, wdata=0x0003FFFF → `gpio_wr_en`=1 with addr=1, data=0x0003FFFF in the cycle after the request; `m0_ack` one cycle later; `m1_ack` stays 0.
- **m1 read:** preload GPIO reg2 = 0x000000A5, then m1 reads addr=2 → `gpio_rd_en`=1 one cycle after the request; `m1_ack`=1 and `m1_rdata`=0x000000A5 3 cycles after the request; `m0_rdata` unchanged.
- **Simultaneous first contest:** `m0_req` and `m1_req` rise in the same cycle after reset → m0 granted first (`last_grant`=0), m1 served immediately after (`last_grant`=1); exactly two strobes total.
- **Continuous contention:** both masters hold `req` high for 12 writes → grants alternate m0, m1, m0, …; every write takes 3 cycles; `gpio_rd_en`/`gpio_wr_en` never both high.
- **Reset mid-read:** assert `reset_n`=0 in the WAIT cycle of an m0 read → next cycle state is IDLE, `busy`=0, `m0_ack` never pulses, `m0_rdata`=0, `last_grant`=1.
- **Back-to-back single master:** m1 keeps `req` high across ack with m0 idle → a new m1 transaction starts in the IDLE cycle after DONE; the new latched fields are used.

Source files
------------

// File: rtl/gpio_bus_arbiter.sv
// ---------------------------------------------------------------------------
// gpio_bus_arbiter
//
// Round-robin arbiter and sequencer in front of the GPIO register port.
// Two masters (m0 = CPU load/store unit, m1 = debug/test sequencer) raise a
// level-held request. The winner's command is latched and issued as exactly
// one single-cycle rd_en or wr_en strobe. Completion is signalled to that
// master with a one-cycle ack, and read data is returned for reads.
//
// Ports:
//   clk, reset_n          : clock, synchronous active-low reset
//   mX_req/we/addr/wdata  : master X request and command fields (X = 0, 1)
//   mX_ack, mX_rdata      : master X completion pulse and held read data
//   gpio_addr/data_in     : address and write data to the GPIO block
//   gpio_rd_en/wr_en      : single-cycle GPIO access strobes
//   gpio_data_out         : registered GPIO read data (valid cycle after rd_en)
//   busy                  : high whenever the sequencer is not idle
//   last_grant            : index of the most recently granted master
// ---------------------------------------------------------------------------
module gpio_bus_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] gpio_addr,
    output logic [DATA_W-1:0] gpio_data_in,
    output logic              gpio_rd_en,
    output logic              gpio_wr_en,
    input  logic [DATA_W-1:0] gpio_data_out,
    output logic              busy,
    output logic              last_grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_r;
    logic              we_r;

    logic              any_req_s;
    logic              win_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;

    // Round-robin winner selection and mux of the winner's command fields.
    always_comb begin
        any_req_s = m0_req | m1_req;
        if (m0_req && m1_req) begin
            // Contention: the master that was not served last goes next.
            win_s = ~last_grant;
        end else if (m1_req) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
        if (win_s) begin
            sel_we_s    = m1_we;
            sel_addr_s  = m1_addr;
            sel_wdata_s = m1_wdata;
        end else begin
            sel_we_s    = m0_we;
            sel_addr_s  = m0_addr;
            sel_wdata_s = m0_wdata;
        end
    end

    // Sequencer FSM with all outputs registered.
    // The latched address/data live directly in gpio_addr/gpio_data_in: they
    // are loaded at grant so the strobe cycle (ISSUE) already presents them,
    // and they simply hold outside ISSUE. Reads leave gpio_data_in untouched.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            we_r         <= 1'b0;
            last_grant   <= 1'b1;
            busy         <= 1'b0;
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;
            m0_rdata     <= {DATA_W{1'b0}};
            m1_rdata     <= {DATA_W{1'b0}};
            gpio_addr    <= {ADDR_W{1'b0}};
            gpio_data_in <= {DATA_W{1'b0}};
            gpio_rd_en   <= 1'b0;
            gpio_wr_en   <= 1'b0;
        end else begin
            // Strobes and acks are single-cycle pulses unless re-armed below.
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            gpio_rd_en <= 1'b0;
            gpio_wr_en <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        last_grant <= win_s;
                        we_r       <= sel_we_s;
                        gpio_addr  <= sel_addr_s;
                        if (sel_we_s) begin
                            gpio_data_in <= sel_wdata_s;
                            gpio_wr_en   <= 1'b1;
                        end else begin
                            gpio_rd_en   <= 1'b1;
                        end
                        busy    <= 1'b1;
                        state_r <= ISSUE;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    if (we_r) begin
                        // Write completes now; ack shows in DONE.
                        m0_ack  <= ~last_grant;
                        m1_ack  <= last_grant;
                        state_r <= DONE;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    // GPIO read data is valid in this cycle.
                    if (last_grant) begin
                        m1_rdata <= gpio_data_out;
                    end else begin
                        m0_rdata <= gpio_data_out;
                    end
                    m0_ack  <= ~last_grant;
                    m1_ack  <= last_grant;
                    state_r <= DONE;
                end
                DONE: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_gpio_bus_arbiter
//
// Self-checking bench for gpio_bus_arbiter. A small GPIO register model sits
// on the slave side. Each scenario task pushes the transactions it expects
// into a scoreboard queue when it drives requests, and pops/compares them as
// strobes and acks appear. Outputs are sampled 1 time unit after the rising
// edge; inputs are driven at the same point.
// ---------------------------------------------------------------------------
module tb_gpio_bus_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 2;

    logic              clk;
    logic              reset_n;
    logic              m0_req, m0_we, m1_req, m1_we;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic              m0_ack, m1_ack;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic [ADDR_W-1:0] gpio_addr;
    logic [DATA_W-1:0] gpio_data_in;
    logic              gpio_rd_en, gpio_wr_en;
    logic [DATA_W-1:0] gpio_data_out;
    logic              busy, last_grant;

    typedef struct {
        logic              master;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   passes = 0;

    // GPIO register model with a bench-side preload port.
    logic [DATA_W-1:0] regs [4];
    logic              preload_en;
    logic [ADDR_W-1:0] preload_addr;
    logic [DATA_W-1:0] preload_data;

    gpio_bus_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .gpio_addr(gpio_addr), .gpio_data_in(gpio_data_in),
        .gpio_rd_en(gpio_rd_en), .gpio_wr_en(gpio_wr_en),
        .gpio_data_out(gpio_data_out), .busy(busy), .last_grant(last_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // GPIO slave model: registered read data, write on strobe.
    always @(posedge clk) begin
        if (preload_en) regs[preload_addr] <= preload_data;
        else if (gpio_wr_en) regs[gpio_addr] <= gpio_data_in;
        if (gpio_rd_en) gpio_data_out <= regs[gpio_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passes++;
        checks++; if ({m0_ack, m1_ack, gpio_rd_en, gpio_wr_en} !== 4'b0000)
            $display("FAIL reset_pulses got=%b exp=0000", {m0_ack, m1_ack, gpio_rd_en, gpio_wr_en}); else passes++;
        checks++; if (last_grant !== 1'b1) $display("FAIL reset_last_grant got=%b exp=1", last_grant); else passes++;
        checks++; if (gpio_addr !== 2'd0 || gpio_data_in !== 32'd0)
            $display("FAIL reset_gpio got addr=%0d data=%h exp 0/0", gpio_addr, gpio_data_in); else passes++;
        checks++; if (m0_rdata !== 32'd0 || m1_rdata !== 32'd0)
            $display("FAIL reset_rdata got %h/%h exp 0/0", m0_rdata, m1_rdata); else passes++;
    endtask

    task automatic test_m0_write();
        exp_q.delete();
        m0_we = 1'b1; m0_addr = 2'd1; m0_wdata = 32'h0003FFFF; m0_req = 1'b1;
        e.master = 1'b0; e.we = 1'b1; e.addr = 2'd1; e.data = 32'h0003FFFF; exp_q.push_back(e);
        step();
        checks++; if (gpio_wr_en !== 1'b1 || gpio_rd_en !== 1'b0)
            $display("FAIL m0w_strobe got wr=%b rd=%b exp wr=1 rd=0", gpio_wr_en, gpio_rd_en); else passes++;
        checks++; if (gpio_addr !== exp_q[0].addr || gpio_data_in !== exp_q[0].data)
            $display("FAIL m0w_fields got %0d/%h exp %0d/%h", gpio_addr, gpio_data_in, exp_q[0].addr, exp_q[0].data); else passes++;
        checks++; if (m0_ack !== 1'b0) $display("FAIL m0w_early_ack got=%b exp=0", m0_ack); else passes++;
        step();
        e = exp_q.pop_front();
        checks++; if ({m0_ack, m1_ack} !== {~e.master, e.master})
            $display("FAIL m0w_ack got=%b%b exp=%b%b", m0_ack, m1_ack, ~e.master, e.master); else passes++;
        checks++; if (gpio_wr_en !== 1'b0) $display("FAIL m0w_strobe_len got=%b exp=0", gpio_wr_en); else passes++;
        m0_req = 1'b0;
        step();
        checks++; if (m0_ack !== 1'b0 || busy !== 1'b0)
            $display("FAIL m0w_after got ack=%b busy=%b exp 0/0", m0_ack, busy); else passes++;
    endtask

    task automatic test_m1_read();
        exp_q.delete();
        preload_addr = 2'd2; preload_data = 32'h000000A5; preload_en = 1'b1;
        step();
        preload_en = 1'b0;
        m1_we = 1'b0; m1_addr = 2'd2; m1_wdata = 32'hFFFFFFFF; m1_req = 1'b1;
        e.master = 1'b1; e.we = 1'b0; e.addr = 2'd2; e.data = 32'h000000A5; exp_q.push_back(e);
        step();
        checks++; if (gpio_rd_en !== 1'b1 || gpio_wr_en !== 1'b0 || gpio_addr !== 2'd2)
            $display("FAIL m1r_strobe got rd=%b wr=%b addr=%0d exp 1/0/2", gpio_rd_en, gpio_wr_en, gpio_addr); else passes++;
        checks++; if (gpio_data_in !== 32'h0003FFFF)
            $display("FAIL m1r_data_in_hold got=%h exp=0003ffff", gpio_data_in); else passes++;
        step();
        checks++; if (m1_ack !== 1'b0 || gpio_rd_en !== 1'b0)
            $display("FAIL m1r_wait got ack=%b rd=%b exp 0/0", m1_ack, gpio_rd_en); else passes++;
        step();
        e = exp_q.pop_front();
        checks++; if (m1_ack !== 1'b1 || m0_ack !== 1'b0)
            $display("FAIL m1r_ack got m0=%b m1=%b exp 0/1", m0_ack, m1_ack); else passes++;
        checks++; if (m1_rdata !== e.data) $display("FAIL m1r_rdata got=%h exp=%h", m1_rdata, e.data); else passes++;
        checks++; if (m0_rdata !== 32'd0) $display("FAIL m1r_m0_rdata got=%h exp=0", m0_rdata); else passes++;
        m1_req = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_read();
        int ack_seen;
        m0_we = 1'b0; m0_addr = 2'd1; m0_req = 1'b1;
        step();
        checks++; if (gpio_rd_en !== 1'b1) $display("FAIL rmid_rd got=%b exp=1", gpio_rd_en); else passes++;
        step();
        checks++; if (busy !== 1'b1 || m0_ack !== 1'b0)
            $display("FAIL rmid_wait got busy=%b ack=%b exp 1/0", busy, m0_ack); else passes++;
        reset_n = 1'b0;
        step();
        checks++; if (busy !== 1'b0 || m0_ack !== 1'b0 || gpio_rd_en !== 1'b0)
            $display("FAIL rmid_state got busy=%b ack=%b rd=%b exp 0/0/0", busy, m0_ack, gpio_rd_en); else passes++;
        checks++; if (m0_rdata !== 32'd0 || m1_rdata !== 32'd0)
            $display("FAIL rmid_rdata got %h/%h exp 0/0", m0_rdata, m1_rdata); else passes++;
        checks++; if (last_grant !== 1'b1 || gpio_addr !== 2'd0)
            $display("FAIL rmid_grant got lg=%b addr=%0d exp 1/0", last_grant, gpio_addr); else passes++;
        reset_n = 1'b1; m0_req = 1'b0;
        ack_seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (m0_ack === 1'b1 || m1_ack === 1'b1) ack_seen++;
        end
        checks++; if (ack_seen != 0) $display("FAIL rmid_no_ack got=%0d acks exp=0", ack_seen); else passes++;
    endtask

    task automatic test_simultaneous();
        int strobes, acks, c;
        do_reset();
        exp_q.delete();
        m0_we = 1'b1; m0_addr = 2'd0; m0_wdata = 32'h00000005;
        m1_we = 1'b1; m1_addr = 2'd3; m1_wdata = 32'h00000006;
        e.master = 1'b0; e.we = 1'b1; e.addr = 2'd0; e.data = 32'h00000005; exp_q.push_back(e);
        e.master = 1'b1; e.we = 1'b1; e.addr = 2'd3; e.data = 32'h00000006; exp_q.push_back(e);
        m0_req = 1'b1; m1_req = 1'b1;
        strobes = 0; acks = 0; c = 0;
        while (acks < 2 && c < 20) begin
            step(); c++;
            if (gpio_wr_en === 1'b1 || gpio_rd_en === 1'b1) begin
                strobes++;
                checks++;
                if (exp_q.size() == 0) $display("FAIL sim_extra_strobe at cycle %0d", c);
                else if (last_grant !== exp_q[0].master || gpio_data_in !== exp_q[0].data)
                    $display("FAIL sim_grant got lg=%b data=%h exp lg=%b data=%h", last_grant, gpio_data_in, exp_q[0].master, exp_q[0].data);
                else passes++;
            end
            if (m0_ack === 1'b1 || m1_ack === 1'b1) begin
                acks++;
                checks++;
                if (exp_q.size() == 0) $display("FAIL sim_extra_ack at cycle %0d", c);
                else begin
                    e = exp_q.pop_front();
                    if ({m0_ack, m1_ack} !== {~e.master, e.master})
                        $display("FAIL sim_ack got=%b%b exp=%b%b", m0_ack, m1_ack, ~e.master, e.master);
                    else passes++;
                end
                if (m0_ack === 1'b1) m0_req = 1'b0;
                if (m1_ack === 1'b1) m1_req = 1'b0;
            end
        end
        for (int i = 0; i < 4; i++) begin
            step();
            if (gpio_wr_en === 1'b1 || gpio_rd_en === 1'b1) strobes++;
        end
        checks++; if (acks != 2) $display("FAIL sim_acks got=%0d exp=2", acks); else passes++;
        checks++; if (strobes != 2) $display("FAIL sim_strobes got=%0d exp=2", strobes); else passes++;
    endtask

    task automatic test_contention();
        int prev_wr, acks, c;
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 12; i++) begin
            e.master = i[0]; e.we = 1'b1;
            e.addr = i[0] ? 2'd3 : 2'd0;
            e.data = i[0] ? 32'hB0B00001 : 32'hA0A00000;
            exp_q.push_back(e);
        end
        m0_we = 1'b1; m0_addr = 2'd0; m0_wdata = 32'hA0A00000;
        m1_we = 1'b1; m1_addr = 2'd3; m1_wdata = 32'hB0B00001;
        m0_req = 1'b1; m1_req = 1'b1;
        prev_wr = -2; acks = 0; c = 0;
        while (acks < 12 && c < 60) begin
            step(); c++;
            checks++; if (gpio_rd_en !== 1'b0) $display("FAIL cont_rd_en got=%b exp=0 cycle %0d", gpio_rd_en, c); else passes++;
            if (gpio_wr_en === 1'b1) begin
                checks++; if (c - prev_wr != 3) $display("FAIL cont_spacing got=%0d exp=3", c - prev_wr); else passes++;
                checks++;
                if (exp_q.size() == 0) $display("FAIL cont_extra_strobe at cycle %0d", c);
                else if (last_grant !== exp_q[0].master || gpio_addr !== exp_q[0].addr || gpio_data_in !== exp_q[0].data)
                    $display("FAIL cont_grant got lg=%b addr=%0d data=%h exp lg=%b addr=%0d data=%h",
                             last_grant, gpio_addr, gpio_data_in, exp_q[0].master, exp_q[0].addr, exp_q[0].data);
                else passes++;
                prev_wr = c;
            end
            if (m0_ack === 1'b1 || m1_ack === 1'b1) begin
                acks++;
                checks++; if (c - prev_wr != 1) $display("FAIL cont_ack_latency got=%0d exp=1", c - prev_wr); else passes++;
                checks++;
                if (exp_q.size() == 0) $display("FAIL cont_extra_ack at cycle %0d", c);
                else begin
                    e = exp_q.pop_front();
                    if ({m0_ack, m1_ack} !== {~e.master, e.master})
                        $display("FAIL cont_ack got=%b%b exp=%b%b", m0_ack, m1_ack, ~e.master, e.master);
                    else passes++;
                end
                if (acks == 12) begin m0_req = 1'b0; m1_req = 1'b0; end
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        checks++; if (acks != 12) $display("FAIL cont_acks got=%0d exp=12", acks); else passes++;
        step(); step();
    endtask

    task automatic test_back_to_back();
        int prev_wr, acks, c;
        exp_q.delete();
        m0_req = 1'b0;
        m1_we = 1'b1; m1_addr = 2'd0; m1_wdata = 32'h11111111; m1_req = 1'b1;
        e.master = 1'b1; e.we = 1'b1; e.addr = 2'd0; e.data = 32'h11111111; exp_q.push_back(e);
        prev_wr = -2; acks = 0; c = 0;
        while (acks < 2 && c < 20) begin
            step(); c++;
            if (gpio_wr_en === 1'b1) begin
                checks++; if (c - prev_wr != 3) $display("FAIL b2b_spacing got=%0d exp=3", c - prev_wr); else passes++;
                checks++;
                if (exp_q.size() == 0) $display("FAIL b2b_extra_strobe at cycle %0d", c);
                else if (gpio_addr !== exp_q[0].addr || gpio_data_in !== exp_q[0].data)
                    $display("FAIL b2b_fields got %0d/%h exp %0d/%h", gpio_addr, gpio_data_in, exp_q[0].addr, exp_q[0].data);
                else passes++;
                prev_wr = c;
            end
            if (m0_ack === 1'b1 || m1_ack === 1'b1) begin
                acks++;
                checks++;
                if (exp_q.size() == 0) $display("FAIL b2b_extra_ack at cycle %0d", c);
                else begin
                    e = exp_q.pop_front();
                    if ({m0_ack, m1_ack} !== {~e.master, e.master})
                        $display("FAIL b2b_ack got=%b%b exp=%b%b", m0_ack, m1_ack, ~e.master, e.master);
                    else passes++;
                end
                if (acks == 1) begin
                    // Keep req high; new fields must be picked up by the next grant.
                    m1_addr = 2'd3; m1_wdata = 32'h22222222;
                    e.master = 1'b1; e.we = 1'b1; e.addr = 2'd3; e.data = 32'h22222222; exp_q.push_back(e);
                end else begin
                    m1_req = 1'b0;
                end
            end
        end
        m1_req = 1'b0;
        checks++; if (acks != 2) $display("FAIL b2b_acks got=%0d exp=2", acks); else passes++;
    endtask

    initial begin
        reset_n = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 2'd0; m0_wdata = 32'd0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 2'd0; m1_wdata = 32'd0;
        preload_en = 1'b0; preload_addr = 2'd0; preload_data = 32'd0;
        test_reset();
        test_m0_write();
        test_m1_read();
        test_reset_mid_read();
        test_simultaneous();
        test_contention();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
